// File: rtl/fxp_mul_seq.sv
// Sequential sign-magnitude fixed-point multiplier.
// Shift-add over the multiplier magnitude, then round, scale and saturate.
module fxp_mul_seq #(
  parameter int SIZE = 32,
  parameter int FRAC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            rnd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] Out,
  output logic            ovf
);

  localparam int M  = SIZE - 1;
  localparam int M2 = 2 * M;
  localparam int CW = $clog2(SIZE);
  localparam int HS = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [M2:0] HALF = (M2+1)'(FRAC > 0) << HS;

  typedef enum logic [1:0] {IDLE, BUSY, NORM, DONE} state_t;

  state_t          state;
  logic [M2-1:0]   acc;
  logic [M2-1:0]   mcand;
  logic [M-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic            sign;
  logic            rnd_q;

  logic [M2:0]     sum;
  logic [M2:0]     shifted;
  logic            sat;
  logic [M-1:0]    mag;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Extra top bit keeps the rounding carry from wrapping.
  always_comb begin
    sum     = {1'b0, acc} + (rnd_q ? HALF : '0);
    shifted = sum >> FRAC;
    sat     = |shifted[M2:M];
    mag     = sat ? '1 : shifted[M-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      rnd_q  <= 1'b0;
      Out    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{M{1'b0}}, A[M-1:0]};
            mplier <= B[M-1:0];
            sign   <= A[M] ^ B[M];
            rnd_q  <= rnd;
            acc    <= '0;
            cnt    <= CW'(M);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= NORM;
        end
        NORM: begin
          // No negative zero: sign only survives a nonzero magnitude.
          Out   <= {sign & (|mag), mag};
          ovf   <= sat;
          state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fxp_mul_seq.md
FXP_MUL_SEQ -- requirements
Module: fxp_mul_seq

Interface
REQ-001 The block SHALL have parameter SIZE, default 32: total word width; bit SIZE-1 is the sign, bits SIZE-2:0 are the unsigned magnitude (sign-magnitude fixed point).
REQ-002 The block SHALL have parameter FRAC, default 16: number of fractional magnitude bits; legal range 0..SIZE-2.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair A/B/rnd is valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 A  input  SIZE  multiplicand, sign-magnitude.
REQ-009 B  input  SIZE  multiplier, sign-magnitude.
REQ-010 rnd  input  1  rounding mode: 0 = truncate, 1 = round half up on magnitude.
REQ-011 out_valid  output  1  Out/ovf hold a valid result.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 Out  output  SIZE  product, sign-magnitude, same format as A/B.
REQ-014 ovf  output  1  magnitude saturated in this result.

Function
REQ-015 States SHALL be IDLE, BUSY, NORM and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 On a rising edge with in_valid=1 in IDLE, the block SHALL capture A, B and rnd, clear the accumulator, load a step counter and enter BUSY.
REQ-019 In BUSY, each cycle SHALL process one multiplier magnitude bit (shift-add into a 2*(SIZE-1)-bit accumulator); after exactly SIZE-1 BUSY cycles the block SHALL enter NORM.
REQ-020 In NORM (one cycle), the block SHALL add 2^(FRAC-1) to the accumulator if rnd=1 and FRAC>0, shift it right by FRAC, and saturate.
REQ-021 Saturation: if the shifted magnitude exceeds 2^(SIZE-1)-1, the magnitude SHALL become 2^(SIZE-1)-1 and ovf SHALL be set, otherwise ovf SHALL be cleared.
REQ-022 Sign SHALL be A[SIZE-1] XOR B[SIZE-1]; if the final magnitude is 0, the sign bit SHALL be forced to 0 (no negative zero).
REQ-023 NORM SHALL always transition to DONE, so out_valid rises on the SIZE-th rising edge after the accepting edge.
REQ-024 In DONE, Out and ovf SHALL remain stable until out_ready=1 is sampled; on that edge the block SHALL return to IDLE.
REQ-025 in_valid SHALL be ignored outside IDLE; operand changes during BUSY/NORM/DONE SHALL NOT affect the result.
REQ-026 Throughput SHALL be at most one operation per SIZE+1 cycles; acceptance and result hand-off SHALL never occur in the same cycle.

Reset
REQ-027 While rst=1, regardless of clock, the block SHALL be in IDLE with in_ready=1, out_valid=0, Out=0, ovf=0, and the accumulator and counter cleared.
REQ-028 rst asserted in any state, including mid-BUSY, SHALL abort the operation; no result for it SHALL ever be presented.

Verification (SIZE=32, FRAC=16)
REQ-029 Basic: A=0x00018000 (1.5), B=0x80020000 (-2.0), rnd=0 -> Out=0x80030000, ovf=0, out_valid on the 32nd edge after accept.
REQ-030 Overflow: A=0x7FFF0000, B=0x00020000 -> Out=0x7FFFFFFF, ovf=1.
REQ-031 Rounding: A=0x00000001, B=0x00008000 -> Out=0x00000001 with rnd=1, Out=0x00000000 with rnd=0.
REQ-032 Negative zero: A=0x80000000, B=0x00010000 -> Out=0x00000000, ovf=0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> Out/ovf/out_valid stable; in_ready=0 and a new in_valid is not accepted until the edge after out_ready=1.
REQ-034 Reset mid-op: assert rst on the 10th BUSY cycle -> immediately in_ready=1, out_valid=0, Out=0; after release, a new operation completes with the correct result and no stale output.
